// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl
//   SPI register controller that runs entirely in the system clock domain.
//   The host SPI pins are oversampled, and fixed 16-bit frames are decoded into
//   a small bank of 8-bit registers. A frame is W (bit15), address (bits14:8)
//   and data (bits7:0), sent MSB first in SPI mode 0. Register updates happen
//   only in the single COMMIT cycle after chip select rises, so the outputs
//   that follow the bank never change while a frame is in flight.
//
// Ports
//   clk        system clock, at least 4x the SCLK frequency
//   rst_n      asynchronous active-low reset
//   sclk       host SPI clock (asynchronous, mode 0)
//   cs_n       host chip select, active low (asynchronous)
//   mosi       host data in (asynchronous)
//   miso       host data out, 0 whenever no read data is being shifted
//   sel        peripheral-select code for the routing mux (reg[0])
//   leds       reg[1][1:0]
//   regs       flat register bank, reg[i] at bits [8i+7:8i]
//   wr_strobe  one-cycle pulse on a register write
//   wr_addr    address of the most recent write (held between writes)
//   frame_err  one-cycle pulse when a frame of the wrong length is discarded

module spi_reg_ctrl #(
  parameter int NREG = 4,
  localparam int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [7:0]        sel,
  output logic [1:0]        leds,
  output logic [NREG*8-1:0] regs,
  output logic              wr_strobe,
  output logic [AW-1:0]     wr_addr,
  output logic              frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t      state;
  logic [2:0]  sclk_sync;
  logic [2:0]  cs_sync;
  logic [1:0]  mosi_sync;
  logic        settled;
  logic        armed;
  logic [4:0]  bit_cnt;
  logic [15:0] shreg;
  logic [15:0] shift_next;
  logic [7:0]  rd_shift;
  logic        rd_active;
  logic [7:0]  reg_q [NREG];

  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;
  logic mosi_bit;

  // True when the 7-bit address field points inside the bank.
  function automatic logic in_range(input logic [6:0] addr);
    return (addr >> AW) == 7'd0;
  endfunction

  // Two-stage synchronisers, plus a third stage on sclk/cs_n for edge
  // detection. Stages reset to the idle level of each pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 3'b000;
      cs_sync   <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      cs_sync   <= {cs_sync[1:0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign mosi_bit  = mosi_sync[1];

  // The cs_n synchroniser resets to 1, so a chip select that is already low
  // when reset releases would look like a fresh falling edge. Frames are only
  // accepted once cs_n has really been sampled high after reset; 'settled'
  // marks that the first synchroniser stage holds a genuine pin sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settled <= 1'b0;
      armed   <= 1'b0;
    end else begin
      settled <= 1'b1;
      if (settled && cs_sync[0]) begin
        armed <= 1'b1;
      end
    end
  end

  assign shift_next = {shreg[14:0], mosi_bit};

  // Frame FSM and register bank. On the 8th SCLK rise shift_next holds the
  // W bit and the address field, so read data is fetched right there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 5'd0;
      shreg     <= 16'h0000;
      rd_shift  <= 8'h00;
      rd_active <= 1'b0;
      miso      <= 1'b0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
      for (int i = 0; i < NREG; i++) begin
        reg_q[i] <= 8'h00;
      end
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt   <= 5'd0;
          miso      <= 1'b0;
          rd_active <= 1'b0;
          if (cs_fall && armed) begin
            state <= SHIFT;
          end
        end

        SHIFT: begin
          if (sclk_rise) begin
            shreg <= shift_next;
            if (bit_cnt != 5'd17) begin
              bit_cnt <= bit_cnt + 5'd1;
            end
            if (bit_cnt == 5'd7 && !shift_next[7]) begin
              rd_active <= 1'b1;
              rd_shift  <= in_range(shift_next[6:0]) ? reg_q[shift_next[AW-1:0]] : 8'h00;
            end
          end
          // Bits 8..15 go out on the falls that follow rises 8..15.
          if (sclk_fall) begin
            if (rd_active && bit_cnt >= 5'd8 && bit_cnt <= 5'd15) begin
              miso     <= rd_shift[7];
              rd_shift <= {rd_shift[6:0], 1'b0};
            end else begin
              miso <= 1'b0;
            end
          end
          // A simultaneous SCLK edge above is still applied, so COMMIT sees
          // the updated count.
          if (cs_rise) begin
            state <= COMMIT;
          end
        end

        COMMIT: begin
          state     <= IDLE;
          miso      <= 1'b0;
          rd_active <= 1'b0;
          if (bit_cnt == 5'd16) begin
            if (shreg[15] && in_range(shreg[14:8])) begin
              reg_q[shreg[8 +: AW]] <= shreg[7:0];
              wr_strobe             <= 1'b1;
              wr_addr               <= shreg[8 +: AW];
            end
          end else begin
            frame_err <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Flat view of the bank plus the dedicated outputs taken from it.
  always_comb begin
    regs = '0;
    for (int i = 0; i < NREG; i++) begin
      regs[8*i +: 8] = reg_q[i];
    end
  end

  assign sel  = reg_q[0];
  assign leds = reg_q[1][1:0];

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl
//   Testbench for spi_reg_ctrl. A host SPI driver shifts frames in with SCLK
//   phases of 4 clk periods, records what the DUT does around each frame, and
//   each test task compares those observations against a register-bank model.

module tb_spi_reg_ctrl;

  localparam int NREG = 4;
  localparam int AW   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sclk = 1'b0;
  logic              cs_n = 1'b1;
  logic              mosi = 1'b0;
  logic              miso;
  logic [7:0]        sel;
  logic [1:0]        leds;
  logic [NREG*8-1:0] regs;
  logic              wr_strobe;
  logic [AW-1:0]     wr_addr;
  logic              frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the register bank.
  logic [7:0] model [NREG];

  // Observations collected by the frame driver.
  logic [7:0]        obs_rd;
  int                obs_strobe_cnt;
  int                obs_strobe_at;
  int                obs_err_cnt;
  int                obs_err_at;
  int                obs_both;
  logic [NREG*8-1:0] obs_regs_pre;
  logic [NREG*8-1:0] obs_regs_post;
  logic [AW-1:0]     obs_wr_addr;
  logic              obs_sel_moved;
  logic [7:0]        sel_at_start;

  spi_reg_ctrl #(.NREG(NREG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .sel       (sel),
    .leds      (leds),
    .regs      (regs),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, wanted end of test");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [NREG*8-1:0] model_flat();
    logic [NREG*8-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
      v[8*i +: 8] = model[i];
    end
    return v;
  endfunction

  // Applies one frame to the model: a write lands only for exactly 16 bits,
  // W set and an address inside the bank; any other length is an error.
  task automatic model_apply(input logic [15:0] f, input int nbits,
                             output bit exp_wr, output bit exp_err,
                             output logic [7:0] exp_rd);
    int a;
    a       = int'(f[14:8]);
    exp_err = (nbits != 16);
    exp_wr  = (nbits == 16) && f[15] && (a < NREG);
    exp_rd  = (a < NREG) ? model[a] : 8'h00;
    if (exp_wr) begin
      model[a] = f[7:0];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      model[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_begin();
    @(negedge clk);
    cs_n          = 1'b0;
    sel_at_start  = sel;
    obs_sel_moved = 1'b0;
    obs_rd        = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  // Shifts bits [first, first+count) of word, MSB (word[31]) first. Read data
  // for frame bits 8..15 is sampled at the end of the low phase, just before
  // the rise that clocks that bit.
  task automatic shift_bits(input logic [31:0] word, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      mosi = word[31-i];
      repeat (4) begin
        @(negedge clk);
        if (sel !== sel_at_start) obs_sel_moved = 1'b1;
      end
      if (i >= 8 && i < 16) obs_rd = {obs_rd[6:0], miso};
      sclk = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (sel !== sel_at_start) obs_sel_moved = 1'b1;
      end
      sclk = 1'b0;
    end
  endtask

  // Raises cs_n and watches 8 clk cycles; k counts rising edges since the
  // cs_n pin rose.
  task automatic frame_end();
    repeat (2) @(negedge clk);
    cs_n           = 1'b1;
    obs_strobe_cnt = 0;
    obs_strobe_at  = 0;
    obs_err_cnt    = 0;
    obs_err_at     = 0;
    obs_both       = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k <= 3 && sel !== sel_at_start) obs_sel_moved = 1'b1;
      if (wr_strobe === 1'b1) begin
        obs_strobe_cnt++;
        if (obs_strobe_at == 0) obs_strobe_at = k;
        obs_wr_addr = wr_addr;
      end
      if (frame_err === 1'b1) begin
        obs_err_cnt++;
        if (obs_err_at == 0) obs_err_at = k;
      end
      if (wr_strobe === 1'b1 && frame_err === 1'b1) obs_both++;
      if (k == 3) obs_regs_pre = regs;
      if (k == 4) obs_regs_post = regs;
    end
  endtask

  task automatic run_frame(input logic [31:0] word, input int nbits);
    frame_begin();
    shift_bits(word, 0, nbits);
    frame_end();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (regs !== '0 || sel !== 8'h00 || leds !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_bank: regs=%h sel=%h leds=%b, wanted all 0", regs, sel, leds);
    end
    n_checks++;
    if (miso !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_miso: got %b, wanted 0", miso);
    end
    n_checks++;
    if (wr_strobe !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_pulses: wr_strobe=%b frame_err=%b, wanted 0 0", wr_strobe, frame_err);
    end
    n_checks++;
    if (wr_addr !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_wr_addr: got %0d, wanted 0", wr_addr);
    end
  endtask

  task automatic test_write();
    run_frame({16'h8005, 16'h0000}, 16);
    n_checks++;
    if (obs_regs_pre[7:0] !== 8'h00 || obs_sel_moved !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL write_sel_early: sel before 4th edge=%h moved=%b, wanted 00 0", obs_regs_pre[7:0], obs_sel_moved);
    end
    n_checks++;
    if (obs_regs_post[7:0] !== 8'h05 || sel !== 8'h05) begin
      n_fail++;
      $display("[TB] FAIL write_sel: at 4th edge=%h now=%h, wanted 05", obs_regs_post[7:0], sel);
    end
    n_checks++;
    if (obs_strobe_cnt !== 1 || obs_strobe_at !== 4) begin
      n_fail++;
      $display("[TB] FAIL write_strobe: count=%0d at edge %0d, wanted 1 at edge 4", obs_strobe_cnt, obs_strobe_at);
    end
    n_checks++;
    if (obs_wr_addr !== 2'd0 || obs_err_cnt !== 0) begin
      n_fail++;
      $display("[TB] FAIL write_addr: wr_addr=%0d errs=%0d, wanted 0 0", obs_wr_addr, obs_err_cnt);
    end
    model[0] = 8'h05;
  endtask

  task automatic test_read_back();
    run_frame({16'h81A5, 16'h0000}, 16);
    model[1] = 8'hA5;
    n_checks++;
    if (obs_strobe_cnt !== 1 || obs_wr_addr !== 2'd1 || leds !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL rb_write: strobes=%0d wr_addr=%0d leds=%b, wanted 1 1 01", obs_strobe_cnt, obs_wr_addr, leds);
    end
    run_frame({16'h0100, 16'h0000}, 16);
    n_checks++;
    if (obs_rd !== 8'hA5) begin
      n_fail++;
      $display("[TB] FAIL rb_miso: got %h, wanted a5", obs_rd);
    end
    n_checks++;
    if (obs_strobe_cnt !== 0 || obs_err_cnt !== 0) begin
      n_fail++;
      $display("[TB] FAIL rb_pulses: strobes=%0d errs=%0d, wanted 0 0", obs_strobe_cnt, obs_err_cnt);
    end
    n_checks++;
    if (obs_regs_post !== model_flat()) begin
      n_fail++;
      $display("[TB] FAIL rb_regs: got %h, wanted %h", obs_regs_post, model_flat());
    end
  endtask

  task automatic test_bad_length();
    int lens [2] = '{12, 20};
    for (int n = 0; n < 2; n++) begin
      run_frame({16'h82FF, 16'hFFFF}, lens[n]);
      n_checks++;
      if (obs_err_cnt !== 1 || obs_err_at !== 4) begin
        n_fail++;
        $display("[TB] FAIL badlen_err_%0d: count=%0d at edge %0d, wanted 1 at edge 4", lens[n], obs_err_cnt, obs_err_at);
      end
      n_checks++;
      if (obs_strobe_cnt !== 0 || obs_regs_post !== model_flat()) begin
        n_fail++;
        $display("[TB] FAIL badlen_regs_%0d: strobes=%0d regs=%h, wanted 0 %h", lens[n], obs_strobe_cnt, obs_regs_post, model_flat());
      end
    end
  endtask

  task automatic test_out_of_range();
    run_frame({16'h8733, 16'h0000}, 16);
    n_checks++;
    if (obs_strobe_cnt !== 0 || obs_err_cnt !== 0) begin
      n_fail++;
      $display("[TB] FAIL oor_pulses: strobes=%0d errs=%0d, wanted 0 0", obs_strobe_cnt, obs_err_cnt);
    end
    n_checks++;
    if (regs !== model_flat() || wr_addr !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL oor_regs: regs=%h wr_addr=%0d, wanted %h 1", regs, wr_addr, model_flat());
    end
    run_frame({16'h0700, 16'h0000}, 16);
    n_checks++;
    if (obs_rd !== 8'h00 || obs_err_cnt !== 0) begin
      n_fail++;
      $display("[TB] FAIL oor_read: data=%h errs=%0d, wanted 00 0", obs_rd, obs_err_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    frame_begin();
    shift_bits({16'h8103, 16'h0000}, 0, 6);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      model[i] = 8'h00;
    end
    shift_bits({16'h8103, 16'h0000}, 6, 10);
    frame_end();
    n_checks++;
    if (obs_strobe_cnt !== 0 || obs_err_cnt !== 0 || leds !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL midrst_ignored: strobes=%0d errs=%0d leds=%b, wanted 0 0 00", obs_strobe_cnt, obs_err_cnt, leds);
    end
    run_frame({16'h8103, 16'h0000}, 16);
    model[1] = 8'h03;
    n_checks++;
    if (obs_strobe_cnt !== 1 || leds !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL midrst_next: strobes=%0d leds=%b, wanted 1 11", obs_strobe_cnt, leds);
    end
  endtask

  task automatic test_random();
    logic [15:0] f;
    int          nbits;
    int          pick;
    bit          exp_wr;
    bit          exp_err;
    logic [7:0]  exp_rd;
    for (int t = 0; t < 40; t++) begin
      f = 16'($urandom);
      if ($urandom_range(0, 3) != 0) f[14:8] = 7'($urandom_range(0, NREG-1));
      pick = $urandom_range(0, 9);
      if (pick <= 5)      nbits = 16;
      else if (pick == 6) nbits = 12;
      else if (pick == 7) nbits = 20;
      else                nbits = $urandom_range(1, 24);
      model_apply(f, nbits, exp_wr, exp_err, exp_rd);
      run_frame({f, 16'($urandom)}, nbits);
      n_checks++;
      if (obs_strobe_cnt !== int'(exp_wr) || obs_err_cnt !== int'(exp_err) || obs_both !== 0) begin
        n_fail++;
        $display("[TB] FAIL rand_pulses frame=%h bits=%0d: strobes=%0d errs=%0d both=%0d, wanted %0d %0d 0",
                 f, nbits, obs_strobe_cnt, obs_err_cnt, obs_both, exp_wr, exp_err);
      end
      n_checks++;
      if (obs_regs_post !== model_flat() || obs_sel_moved !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL rand_regs frame=%h bits=%0d: regs=%h sel_moved=%b, wanted %h 0",
                 f, nbits, obs_regs_post, obs_sel_moved, model_flat());
      end
      if (exp_wr) begin
        n_checks++;
        if (obs_wr_addr !== f[8 +: AW] || obs_strobe_at !== 4) begin
          n_fail++;
          $display("[TB] FAIL rand_wr_addr frame=%h: addr=%0d at edge %0d, wanted %0d at edge 4",
                   f, obs_wr_addr, obs_strobe_at, f[8 +: AW]);
        end
      end
      if (!f[15] && nbits >= 16) begin
        n_checks++;
        if (obs_rd !== exp_rd) begin
          n_fail++;
          $display("[TB] FAIL rand_read frame=%h bits=%0d: got %h, wanted %h", f, nbits, obs_rd, exp_rd);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] spi_reg_ctrl test start");
    test_reset();
    test_write();
    test_read_back();
    test_bad_length();
    test_out_of_range();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
